// File: rtl/commit_diff_checker.sv
// Lockstep commit-stream comparator: buffers primary (A) and variant (B)
// retirement records independently, compares them in order, and reports the
// first divergence, a FIFO overflow or an excessive lag as sticky status.
//
// Ports:
//   clock, reset (async, active-low)  clock and reset
//   enable                            run / idle
//   a_valid, a_pc, a_data             primary retirement record
//   b_valid, b_pc, b_data             variant retirement record
//   halted                            checker has stopped on a fault
//   mismatch, overflow, lag_timeout   sticky fault flags
//   mismatch_pc_a, mismatch_pc_b      head PCs of the first differing pair
//   match_count                       matching pairs compared (saturating)
module commit_diff_checker #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned LAG_LIMIT = 1024
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            enable,
   input  logic            a_valid,
   input  logic [XLEN-1:0] a_pc,
   input  logic [XLEN-1:0] a_data,
   input  logic            b_valid,
   input  logic [XLEN-1:0] b_pc,
   input  logic [XLEN-1:0] b_data,
   output logic            halted,
   output logic            mismatch,
   output logic            overflow,
   output logic            lag_timeout,
   output logic [XLEN-1:0] mismatch_pc_a,
   output logic [XLEN-1:0] mismatch_pc_b,
   output logic [31:0]     match_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned LW = $clog2(LAG_LIMIT + 1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] data;
   } rec_t;

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t          state_q, state_d;
   rec_t            mem_a [DEPTH];
   rec_t            mem_b [DEPTH];
   logic [PW-1:0]   wr_a_q, wr_a_d, rd_a_q, rd_a_d;
   logic [PW-1:0]   wr_b_q, wr_b_d, rd_b_q, rd_b_d;
   logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
   logic [LW-1:0]   lag_q, lag_d;
   logic            mismatch_d, overflow_d, lag_timeout_d;
   logic [XLEN-1:0] pc_a_d, pc_b_d;
   logic [31:0]     match_d;
   logic            push_a, push_b, pop, ovf_a, ovf_b;
   rec_t            head_a, head_b;

   assign head_a = mem_a[rd_a_q];
   assign head_b = mem_b[rd_b_q];

   // Next-state, FIFO bookkeeping, compare and lag logic
   always_comb begin
      state_d       = state_q;
      wr_a_d        = wr_a_q;
      rd_a_d        = rd_a_q;
      wr_b_d        = wr_b_q;
      rd_b_d        = rd_b_q;
      cnt_a_d       = cnt_a_q;
      cnt_b_d       = cnt_b_q;
      lag_d         = lag_q;
      mismatch_d    = mismatch;
      overflow_d    = overflow;
      lag_timeout_d = lag_timeout;
      pc_a_d        = mismatch_pc_a;
      pc_b_d        = mismatch_pc_b;
      match_d       = match_count;
      push_a        = 1'b0;
      push_b        = 1'b0;
      pop           = 1'b0;
      ovf_a         = 1'b0;
      ovf_b         = 1'b0;

      case (state_q)
         IDLE: if (enable) state_d = RUN;
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
               pop    = (cnt_a_q != '0) && (cnt_b_q != '0);
               // A full FIFO can still accept a push when its head leaves this cycle
               ovf_a  = a_valid && (cnt_a_q == CW'(DEPTH)) && !pop;
               ovf_b  = b_valid && (cnt_b_q == CW'(DEPTH)) && !pop;
               push_a = a_valid && !ovf_a;
               push_b = b_valid && !ovf_b;

               if (push_a) wr_a_d = wr_a_q + PW'(1);
               if (push_b) wr_b_d = wr_b_q + PW'(1);
               if (pop) begin
                  rd_a_d = rd_a_q + PW'(1);
                  rd_b_d = rd_b_q + PW'(1);
               end
               cnt_a_d = cnt_a_q + CW'(push_a) - CW'(pop);
               cnt_b_d = cnt_b_q + CW'(push_b) - CW'(pop);

               if (pop) begin
                  if (head_a == head_b) begin
                     if (match_count != '1) match_d = match_count + 32'd1;
                  end else begin
                     mismatch_d = 1'b1;
                     pc_a_d     = head_a.pc;
                     pc_b_d     = head_b.pc;
                  end
               end

               // Lag only accrues while exactly one side is holding entries
               if ((cnt_a_q != '0) ^ (cnt_b_q != '0)) begin
                  if (lag_q != LW'(LAG_LIMIT)) lag_d = lag_q + LW'(1);
                  if (lag_d == LW'(LAG_LIMIT)) lag_timeout_d = 1'b1;
               end else begin
                  lag_d = '0;
               end

               if (ovf_a || ovf_b) overflow_d = 1'b1;
               if (ovf_a || ovf_b || (mismatch_d && !mismatch) ||
                   (lag_timeout_d && !lag_timeout)) state_d = HALT;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // State and status registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         wr_a_q        <= '0;
         rd_a_q        <= '0;
         wr_b_q        <= '0;
         rd_b_q        <= '0;
         cnt_a_q       <= '0;
         cnt_b_q       <= '0;
         lag_q         <= '0;
         halted        <= 1'b0;
         mismatch      <= 1'b0;
         overflow      <= 1'b0;
         lag_timeout   <= 1'b0;
         mismatch_pc_a <= '0;
         mismatch_pc_b <= '0;
         match_count   <= '0;
      end else begin
         state_q       <= state_d;
         wr_a_q        <= wr_a_d;
         rd_a_q        <= rd_a_d;
         wr_b_q        <= wr_b_d;
         rd_b_q        <= rd_b_d;
         cnt_a_q       <= cnt_a_d;
         cnt_b_q       <= cnt_b_d;
         lag_q         <= lag_d;
         halted        <= (state_d == HALT);
         mismatch      <= mismatch_d;
         overflow      <= overflow_d;
         lag_timeout   <= lag_timeout_d;
         mismatch_pc_a <= pc_a_d;
         mismatch_pc_b <= pc_b_d;
         match_count   <= match_d;
      end
   end

   // FIFO storage; contents are don't-care while the count says empty
   always_ff @(posedge clock) begin
      if (push_a) mem_a[wr_a_q] <= '{pc: a_pc, data: a_data};
      if (push_b) mem_b[wr_b_q] <= '{pc: b_pc, data: b_data};
   end

endmodule

// File: tb/tb_commit_diff_checker.sv
// Scoreboard bench for commit_diff_checker: stimulus queues expected status
// events, a negedge monitor pops one per observed status change and checks it.
module tb_commit_diff_checker;

   localparam int unsigned XLEN = 64;

   logic            clock, reset, enable;
   logic            a_valid, b_valid;
   logic [XLEN-1:0] a_pc, a_data, b_pc, b_data;
   logic            halted, mismatch, overflow, lag_timeout;
   logic [XLEN-1:0] mismatch_pc_a, mismatch_pc_b;
   logic [31:0]     match_count;

   commit_diff_checker #(.XLEN(XLEN), .DEPTH(8), .LAG_LIMIT(16)) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .a_valid(a_valid), .a_pc(a_pc), .a_data(a_data),
      .b_valid(b_valid), .b_pc(b_pc), .b_data(b_data),
      .halted(halted), .mismatch(mismatch), .overflow(overflow),
      .lag_timeout(lag_timeout), .mismatch_pc_a(mismatch_pc_a),
      .mismatch_pc_b(mismatch_pc_b), .match_count(match_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // kind: 0 match, 1 mismatch, 2 overflow, 3 lag timeout
   typedef struct {
      int          kind;
      logic [63:0] pa;
      logic [63:0] pb;
      logic [31:0] cnt;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic void expect_ev(input int k, input logic [63:0] pa,
                                     input logic [63:0] pb, input logic [31:0] c);
      ev_t e;
      e.kind = k; e.pa = pa; e.pb = pb; e.cnt = c;
      exp_q.push_back(e);
   endfunction

   task automatic mon_event(input int kind);
      ev_t e;
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_event: got kind %0d count %0d required no event", kind, match_count);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 64'(kind), 64'(e.kind));
         check("event_count", 64'(match_count), 64'(e.cnt));
         if (kind == 1) begin
            check("mismatch_pc_a", mismatch_pc_a, e.pa);
            check("mismatch_pc_b", mismatch_pc_b, e.pb);
         end
         if (kind != 0) check("halted_on_fault", 64'(halted), 64'd1);
      end
   endtask

   // Monitor: every status change is one DUT "output transaction"
   logic [31:0] prev_cnt;
   logic        prev_mm, prev_ov, prev_lt;
   always @(negedge clock) begin
      if (!reset) begin
         prev_cnt = '0; prev_mm = 1'b0; prev_ov = 1'b0; prev_lt = 1'b0;
      end else begin
         if (match_count !== prev_cnt) mon_event(0);
         if (mismatch && !prev_mm)     mon_event(1);
         if (overflow && !prev_ov)     mon_event(2);
         if (lag_timeout && !prev_lt)  mon_event(3);
         prev_cnt = match_count; prev_mm = mismatch;
         prev_ov = overflow;     prev_lt = lag_timeout;
      end
   end

   task automatic step(input logic av, input logic [63:0] apc, input logic [63:0] ad,
                       input logic bv, input logic [63:0] bpc, input logic [63:0] bd);
      a_valid = av; a_pc = apc; a_data = ad;
      b_valid = bv; b_pc = bpc; b_data = bd;
      @(posedge clock); #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      enable = 1'b0;
      reset  = 1'b0;
      idle(2);
      reset  = 1'b1;
      enable = 1'b1;
      idle(1);   // IDLE -> RUN
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
      check(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   function automatic logic [63:0] pc_of(input int i);
      return 64'h8000_0000 + 64'(4 * i);
   endfunction

   initial begin
      int k;
      reset = 1'b0; enable = 1'b0;
      a_valid = 1'b0; b_valid = 1'b0;
      a_pc = '0; a_data = '0; b_pc = '0; b_data = '0;
      #1;
      check("reset_halted", 64'(halted), 64'd0);
      check("reset_match_count", 64'(match_count), 64'd0);
      check("reset_flags", 64'({mismatch, overflow, lag_timeout}), 64'd0);

      // Lockstep match
      do_reset();
      for (int i = 0; i < 100; i++) begin
         expect_ev(0, '0, '0, 32'(i + 1));
         step(1'b1, pc_of(i), 64'(i), 1'b1, pc_of(i), 64'(i));
      end
      idle(3);
      drain("lockstep_drain");
      check("lockstep_count", 64'(match_count), 64'd100);
      check("lockstep_flags", 64'({mismatch, overflow, lag_timeout}), 64'd0);
      check("lockstep_halted", 64'(halted), 64'd0);

      // B skewed 5 cycles behind A, pointers wrap twice
      do_reset();
      for (int t = 0; t < 25; t++) begin
         if (t >= 5) expect_ev(0, '0, '0, 32'(t - 4));
         step(t < 20, pc_of(t), 64'(t), t >= 5, pc_of(t - 5), 64'(t - 5));
      end
      idle(3);
      drain("skew_drain");
      check("skew_count", 64'(match_count), 64'd20);
      check("skew_overflow", 64'(overflow), 64'd0);
      check("skew_halted", 64'(halted), 64'd0);

      // Divergence on record 7
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i < 7)  expect_ev(0, '0, '0, 32'(i + 1));
         if (i == 7) expect_ev(1, pc_of(7), pc_of(7), 32'd7);
         step(1'b1, pc_of(i), (i == 7) ? 64'h1 : 64'(i),
              1'b1, pc_of(i), (i == 7) ? 64'h2 : 64'(i));
      end
      for (int i = 10; i < 14; i++) step(1'b1, pc_of(i), 64'(i), 1'b1, pc_of(i), 64'(i));
      idle(2);
      drain("diverge_drain");
      check("diverge_mismatch", 64'(mismatch), 64'd1);
      check("diverge_pc_a", mismatch_pc_a, 64'h8000_001c);
      check("diverge_pc_b", mismatch_pc_b, 64'h8000_001c);
      check("diverge_count_held", 64'(match_count), 64'd7);
      check("diverge_halted", 64'(halted), 64'd1);

      // Overflow: A only, 9 pushes into depth 8
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if (i == 8) expect_ev(2, '0, '0, 32'd0);
         step(1'b1, pc_of(i), 64'(i), 1'b0, '0, '0);
         if (i == 7) check("overflow_not_yet", 64'(overflow), 64'd0);
      end
      check("overflow_on_9th", 64'(overflow), 64'd1);
      idle(2);
      drain("overflow_drain");
      check("overflow_halted", 64'(halted), 64'd1);
      check("overflow_no_mismatch", 64'(mismatch), 64'd0);

      // Lag timeout: one A record, B silent
      do_reset();
      expect_ev(3, '0, '0, 32'd0);
      step(1'b1, pc_of(0), 64'd0, 1'b0, '0, '0);
      k = 0;
      a_valid = 1'b0;
      while (k < 40 && !lag_timeout) begin
         @(posedge clock); #1;
         k++;
      end
      check("lag_cycles", 64'(k), 64'd16);
      idle(2);
      drain("lag_drain");
      check("lag_halted", 64'(halted), 64'd1);

      // Async reset between edges while halted with FIFO A occupied
      #2;
      reset = 1'b0;
      #1;
      check("async_reset_status", 64'({halted, mismatch, overflow, lag_timeout}), 64'd0);
      check("async_reset_count", 64'(match_count), 64'd0);
      check("async_reset_pcs", mismatch_pc_a | mismatch_pc_b, 64'd0);
      @(negedge clock); #1;
      reset = 1'b1;
      enable = 1'b1;
      @(posedge clock); #1;
      expect_ev(0, '0, '0, 32'd1);
      step(1'b1, pc_of(3), 64'h55, 1'b1, pc_of(3), 64'h55);
      idle(3);
      drain("post_reset_drain");
      check("post_reset_count", 64'(match_count), 64'd1);
      check("post_reset_halted", 64'(halted), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/commit_diff_checker.md
Name: commit_diff_checker

Overview:
- Lockstep commit-stream comparator between the primary TestHarness and the variant TestHarness (HASVARIANT build).
- Consumes one retirement record per cycle from each instance.
- Buffers the two streams independently so they may skew, then compares them in order.
- Reports the first divergence, a buffer overflow or an excessive lag as sticky status. The top-level bench turns that status into its failure/reason reporting.

Parameters:
- XLEN, 64, width of the PC and writeback-data fields.
- DEPTH, 8, entries per side FIFO; power of 2, minimum 2.
- LAG_LIMIT, 1024, consecutive cycles one side may hold entries while the other is empty before timeout; minimum 1.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- enable  in  1  high = run; low = idle (no pushes, no compares).
- a_valid  in  1  primary instance retired a record this cycle.
- a_pc  in  XLEN  primary retired PC.
- a_data  in  XLEN  primary writeback data.
- b_valid  in  1  variant instance retired a record this cycle.
- b_pc  in  XLEN  variant retired PC.
- b_data  in  XLEN  variant writeback data.
- halted  out  1  checker in HALT state.
- mismatch  out  1  sticky: compared pair differed.
- overflow  out  1  sticky: push into a full FIFO.
- lag_timeout  out  1  sticky: lag counter reached LAG_LIMIT.
- mismatch_pc_a  out  XLEN  primary PC of the first mismatching pair.
- mismatch_pc_b  out  XLEN  variant PC of the first mismatching pair.
- match_count  out  32  number of matching pairs compared; saturates at 2^32-1.

Behaviour:
- Reset (reset low, asynchronous): all outputs 0, both FIFOs empty, lag counter 0, state IDLE.
- FSM states:
  - IDLE: go to RUN when enable=1.
  - RUN: go to IDLE when enable=0; FIFO contents and counters are retained.
  - HALT: entered from RUN when any of mismatch, overflow or lag_timeout is set that cycle. HALT is left only by reset. In HALT there are no pushes, no pops, and all outputs hold.
- Push, RUN only:
  - a_valid=1 writes {a_pc, a_data} to FIFO A at the rising edge; same for side B.
  - A push into a full FIFO in a cycle where that FIFO is not also popped drops the record, sets overflow and goes to HALT.
  - A push into a full FIFO is allowed when a pop occurs in the same cycle.
- Compare, RUN only:
  - When both FIFOs are non-empty at the start of a cycle, both heads are popped at that edge and compared on the full {pc, data}.
  - Equal: match_count increments.
  - Unequal: mismatch=1, mismatch_pc_a/mismatch_pc_b capture the head PCs, go to HALT.
- Latency:
  - Records pushed on both sides at edge N are compared at edge N+1.
  - mismatch is visible after edge N+1.
  - Throughput is one compare per cycle.
- Lag counter, RUN only:
  - Increments each cycle in which exactly one FIFO is non-empty.
  - Clears when both FIFOs are empty or both are non-empty.
  - On reaching LAG_LIMIT: lag_timeout=1, go to HALT.
  - Width is clog2(LAG_LIMIT+1); it never wraps.
- Simultaneous events: every fault condition detected in the same cycle sets its own flag. The mismatch PC capture is independent of the other flags.
- FIFO pointers are DEPTH-modulo and wrap cleanly; a count field distinguishes full from empty.
- enable low in RUN: in-flight entries are held, and the lag counter holds its value rather than clearing.
- halted = (state == HALT).

Test Plan:
- Lockstep match: after reset, 100 identical records on both sides in the same cycles, pc=0x80000000+4i, data=i -> match_count=100, all fault flags 0, halted=0.
- Skewed match with wrap: B delayed 5 cycles, 20 identical records -> match_count=20, no overflow, FIFO pointers wrap at least twice.
- Divergence: record 7 has a_data=0x1, b_data=0x2, pc=0x8000001c -> mismatch=1 at the edge after both are present. mismatch_pc_a=mismatch_pc_b=0x8000001c, match_count=7, halted=1, later inputs ignored.
- Overflow: only A pushes, 9 records with DEPTH=8 -> overflow=1 on the 9th push, halted=1, mismatch=0.
- Lag timeout with LAG_LIMIT=16: one A record, B silent -> lag_timeout=1 after 16 lag cycles, halted=1.
- Reset mid-run: assert reset low asynchronously between edges while halted=1 and FIFOs hold data -> all outputs 0 immediately. After release, a fresh matching record increments match_count to 1.
